// File: rtl/mii_sched_pkg.sv
// mii_sched_pkg: shared states, codes and padding helper for the MII frame scheduler
package mii_sched_pkg;
  typedef enum logic [2:0] {IDLE, ARB, START, WAIT_V, SEND, GAP} state_t;
  localparam logic [7:0]  NO_PADDING  = 8'd2;
  localparam logic [15:0] MIN_PAYLOAD = 16'd46;
  localparam logic [7:0]  IDLE_CODE   = 8'h07;
  localparam logic [7:0]  START_CODE  = 8'hFB;
  localparam logic [7:0]  EOF_CODE    = 8'hFD;
  function automatic logic [15:0] pad_len(input logic [15:0] len, input logic [7:0] intr);
    return (intr != NO_PADDING && len < MIN_PAYLOAD) ? MIN_PAYLOAD : len;
  endfunction
endpackage

// File: rtl/mii_frame_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
module rr_arbiter #(
  parameter int N = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);
  // scan from the farthest offset down so the nearest set bit overwrites the rest
  always_comb begin
    gnt_o = '0;
    for (int i = N - 1; i >= 0; i--)
      if (|(req_i & (N'(1) << ((int'(ptr_i) + i) % N)))) gnt_o = N'(1) << ((int'(ptr_i) + i) % N);
  end
endmodule

// File: rtl/mii_frame_scheduler.sv
// mii_frame_scheduler: round-robin sharing of one MII frame generator among NUM_REQ sources
module mii_frame_scheduler
  import mii_sched_pkg::*;
#(
  parameter int NUM_REQ          = 4,
  parameter int PAYLOAD_MAX_SIZE = 1500,
  parameter int TIMEOUT_CYCLES   = 64
) (
  input  logic                    clk,
  input  logic                    i_rst_n,
  input  logic                    i_enable,
  input  logic [NUM_REQ-1:0]      i_req,
  input  logic [16*NUM_REQ-1:0]   i_len,
  input  logic [8*NUM_REQ-1:0]    i_intr,
  input  logic [7:0]              i_ipg_cycles,
  input  logic                    i_gen_valid,
  output logic                    o_gen_start,
  output logic [15:0]             o_gen_len,
  output logic [7:0]              o_gen_intr,
  output logic [NUM_REQ-1:0]      o_grant,
  output logic [NUM_REQ-1:0]      o_ack,
  output logic                    o_len_err,
  output logic                    o_timeout_err,
  output logic                    o_busy,
  output logic [31:0]             o_frame_count
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  state_t state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, win_idx;
  logic [NUM_REQ-1:0] grant_q, grant_d, ack_q, ack_d, gnt;
  logic [15:0] len_q, len_d, timer_q, timer_d, win_len, gap;
  logic [7:0] intr_q, intr_d, win_intr;
  logic start_q, start_d, len_err_q, len_err_d, tout_q, tout_d;
  logic [31:0] count_q, count_d;
  rr_arbiter #(.N(NUM_REQ)) u_arb (.req_i(i_req), .ptr_i(ptr_q), .gnt_o(gnt));
  assign gap = (i_ipg_cycles == 8'd0) ? 16'd1 : 16'(i_ipg_cycles);
  // select the winning source's length, interrupt code and index
  always_comb begin
    win_len = '0;
    win_intr = '0;
    win_idx = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (gnt[k]) begin
        win_len = i_len[16*k +: 16];
        win_intr = i_intr[8*k +: 8];
        win_idx = PW'(k);
      end
  end
  // next-state and registered-output logic; pulses default low every cycle
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    grant_d = grant_q;
    len_d = len_q;
    intr_d = intr_q;
    timer_d = timer_q;
    count_d = count_q;
    ack_d = '0;
    start_d = 1'b0;
    len_err_d = 1'b0;
    tout_d = 1'b0;
    case (state_q)
      IDLE: state_d = (i_enable && |i_req) ? ARB : IDLE;
      ARB: begin
        state_d = IDLE;
        if (|gnt) begin
          ptr_d = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
          len_d = pad_len(win_len, win_intr);
          intr_d = win_intr;
          if (win_len > 16'(PAYLOAD_MAX_SIZE)) begin
            len_err_d = 1'b1;
            ack_d = gnt;
          end else begin
            grant_d = gnt;
            state_d = START;
          end
        end
      end
      START: begin
        start_d = 1'b1;
        timer_d = '0;
        state_d = WAIT_V;
      end
      WAIT_V: begin
        if (i_gen_valid) state_d = SEND;
        else if (timer_q == 16'(TIMEOUT_CYCLES - 1)) begin
          tout_d = 1'b1;
          ack_d = grant_q;
          grant_d = '0;
          timer_d = gap;
          state_d = GAP;
        end else timer_d = timer_q + 16'd1;
      end
      SEND: begin
        if (!i_gen_valid) begin
          ack_d = grant_q;
          count_d = count_q + 32'd1;
          grant_d = '0;
          timer_d = gap;
          state_d = GAP;
        end
      end
      GAP: begin
        state_d = (timer_q <= 16'd1) ? IDLE : GAP;
        timer_d = (timer_q <= 16'd1) ? timer_q : timer_q - 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and output registers; reset aborts any frame without an ack
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      ptr_q <= '0;
      grant_q <= '0;
      ack_q <= '0;
      len_q <= '0;
      intr_q <= '0;
      timer_q <= '0;
      count_q <= '0;
      start_q <= 1'b0;
      len_err_q <= 1'b0;
      tout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      grant_q <= grant_d;
      ack_q <= ack_d;
      len_q <= len_d;
      intr_q <= intr_d;
      timer_q <= timer_d;
      count_q <= count_d;
      start_q <= start_d;
      len_err_q <= len_err_d;
      tout_q <= tout_d;
    end
  end
  assign o_gen_start = start_q;
  assign o_gen_len = len_q;
  assign o_gen_intr = intr_q;
  assign o_grant = grant_q;
  assign o_ack = ack_q;
  assign o_len_err = len_err_q;
  assign o_timeout_err = tout_q;
  assign o_busy = state_q != IDLE;
  assign o_frame_count = count_q;
endmodule

// File: tb/tb_mii_frame_scheduler.sv
// tb_mii_frame_scheduler: scoreboard bench for the MII frame scheduler
module tb_mii_frame_scheduler;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, gen_valid = 1'b0;
  logic [3:0] req = '0;
  logic [63:0] len = '0;
  logic [31:0] intr = '0;
  logic [7:0] ipg = 8'd4;
  logic o_gen_start, o_len_err, o_timeout_err, o_busy;
  logic [15:0] o_gen_len;
  logic [7:0] o_gen_intr;
  logic [3:0] o_grant, o_ack;
  logic [31:0] o_frame_count;
  typedef struct {int kind; logic [3:0] vec; logic [15:0] len; logic [7:0] intr; logic [31:0] cnt;} exp_t;
  exp_t q[$];
  exp_t me;
  int checks = 0, errors = 0, gen_cycles = 10, mkind;
  logic [31:0] exp_count = '0;
  bit gen_on = 1'b1, gen_kill = 1'b0;

  mii_frame_scheduler dut (
    .clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_req(req), .i_len(len), .i_intr(intr),
    .i_ipg_cycles(ipg), .i_gen_valid(gen_valid), .o_gen_start(o_gen_start), .o_gen_len(o_gen_len),
    .o_gen_intr(o_gen_intr), .o_grant(o_grant), .o_ack(o_ack), .o_len_err(o_len_err),
    .o_timeout_err(o_timeout_err), .o_busy(o_busy), .o_frame_count(o_frame_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_start(input logic [3:0] g, input logic [15:0] l, input logic [7:0] it);
    exp_t e;
    e.kind = 0; e.vec = g; e.len = l; e.intr = it; e.cnt = '0;
    q.push_back(e);
  endtask

  // kind: 1 normal completion, 2 length reject, 3 timeout
  task automatic push_end(input int k, input logic [3:0] a);
    exp_t e;
    if (k == 1) exp_count++;
    e.kind = k; e.vec = a; e.len = '0; e.intr = '0; e.cnt = exp_count;
    q.push_back(e);
  endtask

  task automatic wait_sig(input int which, input int max, input string name, output int n);
    bit hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < max) begin
      @(negedge clk);
      n++;
      hit = (which == 0) ? bit'(o_gen_start) : (which == 1) ? bit'(|o_ack) :
            (which == 2) ? bit'(!o_busy) : bit'(o_timeout_err);
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL %s: no event within %0d cycles", name, n);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_count = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_grant", 32'(o_grant), 32'd0);
    chk("rst_count", o_frame_count, 32'd0);
    chk("rst_gen_len", 32'(o_gen_len), 32'd0);
    chk("rst_gen_start", 32'(o_gen_start), 32'd0);
    chk("rst_ack", 32'(o_ack), 32'd0);
    rst_n = 1'b1;
  endtask

  // monitor: every start or completion pulse is matched against the next expected entry
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_gen_start) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_start: grant=%b expected no start", o_grant);
        end else begin
          me = q.pop_front();
          chk("start_kind", 32'd0, 32'(me.kind));
          chk("start_grant", 32'(o_grant), 32'(me.vec));
          chk("gen_len", 32'(o_gen_len), 32'(me.len));
          chk("gen_intr", 32'(o_gen_intr), 32'(me.intr));
        end
      end
      if (|o_ack || o_len_err || o_timeout_err) begin
        mkind = o_len_err ? 2 : o_timeout_err ? 3 : 1;
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_end: ack=%b kind=%0d expected nothing", o_ack, mkind);
        end else begin
          me = q.pop_front();
          chk("end_kind", 32'(mkind), 32'(me.kind));
          chk("ack", 32'(o_ack), 32'(me.vec));
          chk("frame_count", o_frame_count, me.cnt);
          chk("grant_dropped", 32'(o_grant), 32'd0);
        end
      end
    end
  end

  // generator model: valid rises two cycles after start and stays high gen_cycles cycles
  initial forever begin
    @(negedge clk);
    if (o_gen_start && gen_on) begin
      repeat (2) @(negedge clk);
      gen_valid = 1'b1;
      for (int i = 0; i < gen_cycles && !gen_kill; i++) @(negedge clk);
      gen_valid = 1'b0;
    end
  end

  initial begin
    int n;
    logic [3:0] seq [5];
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    en = 1'b1;
    do_reset();
    // single frame from source 0
    len[15:0] = 16'd64;
    push_start(4'b0001, 16'd64, 8'd0);
    push_end(1, 4'b0001);
    @(negedge clk);
    req = 4'b0001;
    wait_sig(0, 20, "t1_start", n);
    chk("t1_start_latency", 32'(n), 32'd3);
    wait_sig(1, 100, "t1_ack", n);
    req = '0;
    wait_sig(2, 20, "t1_idle", n);
    chk("t1_gap_cycles", 32'(n), 32'd4);
    // all sources requesting: rotation 0,1,2,3,0
    do_reset();
    len = {4{16'd64}};
    for (int i = 0; i < 5; i++) begin
      push_start(seq[i], 16'd64, 8'd0);
      push_end(1, seq[i]);
    end
    req = 4'b1111;
    for (int i = 0; i < 5; i++) wait_sig(1, 100, "t2_ack", n);
    req = '0;
    wait_sig(2, 20, "t2_idle", n);
    // padding rule, and zero idle gap treated as one cycle
    len[47:32] = 16'd20;
    intr[23:16] = 8'd0;
    push_start(4'b0100, 16'd46, 8'd0);
    push_end(1, 4'b0100);
    req = 4'b0100;
    wait_sig(1, 100, "t3a_ack", n);
    req = '0;
    wait_sig(2, 20, "t3a_idle", n);
    len[63:48] = 16'd20;
    intr[31:24] = 8'd2;
    ipg = 8'd0;
    push_start(4'b1000, 16'd20, 8'd2);
    push_end(1, 4'b1000);
    req = 4'b1000;
    wait_sig(1, 100, "t3b_ack", n);
    req = '0;
    wait_sig(2, 20, "t3b_idle", n);
    chk("t3_gap_ipg0", 32'(n), 32'd1);
    ipg = 8'd4;
    // oversize rejected, maximum size accepted
    len[31:16] = 16'd1501;
    push_end(2, 4'b0010);
    req = 4'b0010;
    wait_sig(1, 20, "t4_reject", n);
    req = '0;
    chk("t4_reject_latency", 32'(n), 32'd2);
    chk("t4_idle_after_reject", 32'(o_busy), 32'd0);
    repeat (5) @(negedge clk);
    len[31:16] = 16'd1500;
    push_start(4'b0010, 16'd1500, 8'd0);
    push_end(1, 4'b0010);
    req = 4'b0010;
    wait_sig(1, 100, "t4_ack", n);
    req = '0;
    wait_sig(2, 20, "t4_idle", n);
    // generator never responds: timeout then gap then idle
    gen_on = 1'b0;
    len[15:0] = 16'd100;
    push_start(4'b0001, 16'd100, 8'd0);
    push_end(3, 4'b0001);
    req = 4'b0001;
    wait_sig(0, 20, "t5_start", n);
    wait_sig(3, 200, "t5_timeout", n);
    chk("t5_timeout_latency", 32'(n), 32'd64);
    req = '0;
    wait_sig(2, 20, "t5_idle", n);
    chk("t5_gap_cycles", 32'(n), 32'd4);
    gen_on = 1'b1;
    // reset during SEND aborts without ack and restarts arbitration at source 0
    gen_cycles = 20;
    push_start(4'b0010, 16'd1500, 8'd0);
    req = 4'b0010;
    wait_sig(0, 20, "t6_start", n);
    repeat (5) @(negedge clk);
    chk("t6_busy_in_send", 32'(o_busy), 32'd1);
    chk("t6_grant_in_send", 32'(o_grant), 32'b0010);
    gen_kill = 1'b1;
    rst_n = 1'b0;
    req = '0;
    exp_count = '0;
    #1;
    chk("t6_rst_busy", 32'(o_busy), 32'd0);
    chk("t6_rst_grant", 32'(o_grant), 32'd0);
    chk("t6_rst_ack", 32'(o_ack), 32'd0);
    chk("t6_rst_count", o_frame_count, 32'd0);
    chk("t6_rst_gen_len", 32'(o_gen_len), 32'd0);
    repeat (3) @(negedge clk);
    gen_kill = 1'b0;
    rst_n = 1'b1;
    push_start(4'b0001, 16'd100, 8'd0);
    push_end(1, 4'b0001);
    req = 4'b1111;
    wait_sig(1, 100, "t6_ack", n);
    req = '0;
    wait_sig(2, 20, "t6_idle", n);
    repeat (5) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
